// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the IF/MEM data RAM arbiter
// Contents: FSM state encoding, grant IDs, fixed byte select used for fetches.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  // Fetches always read the full word.
  localparam logic [3:0] IF_SEL = 4'b1111;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - pipeline and RAM-side signal bundle of the data RAM arbiter
// Signals: if_* fetch req/ack port, mem_* load/store req/ack port,
//          ram_* single-port RAM controls with combinational ram_rdata, stall to pipeline.
// Modports: slave = arbiter side, master = pipeline/RAM side.
interface ram_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        stall;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  ram_rdata,
    output if_ack, if_rdata, if_err,
    output mem_ack, mem_rdata, mem_err,
    output ram_en, ram_we, ram_addr, ram_sel, ram_wdata,
    output stall
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output ram_rdata,
    input  if_ack, if_rdata, if_err,
    input  mem_ack, mem_rdata, mem_err,
    input  ram_en, ram_we, ram_addr, ram_sel, ram_wdata,
    input  stall
  );

endinterface

// File: rtl/ram_arb_prio.sv
// rtl/ram_arb_prio.sv - two-way round-robin / fixed-priority pick between IF and MEM
// Ports: if_req, mem_req (eligible requests), last_grant (previous winner),
//        winner (chosen port; only meaningful when at least one request is set).
module ram_arb_prio
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic   if_req,
  input  logic   mem_req,
  input  grant_t last_grant,
  output grant_t winner
);

  always_comb begin
    winner = GRANT_IF;
    if (if_req && mem_req) begin
      if (FIXED_PRIO != 0) begin
        winner = GRANT_MEM;
      end else begin
        // Tie goes to whoever did not win last time.
        winner = (last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
      end
    end else if (mem_req) begin
      winner = GRANT_MEM;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the single-port data RAM between instruction fetch and load/store
// Ports: clk, rst (sync active-high), bus (ram_arbiter_if.slave: IF/MEM req/ack ports,
//        RAM control/address/data lines, pipeline stall).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_BITS  = 19
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  arb_state_t  state_q, state_d;
  grant_t      last_grant_q, winner;
  logic        grant;

  logic [31:0] lat_addr_q;
  logic        lat_we_q;
  logic [3:0]  lat_sel_q;
  logic [31:0] lat_wdata_q;

  logic        if_ack_q, if_err_q;
  logic [31:0] if_rdata_q;
  logic        mem_ack_q, mem_err_q;
  logic [31:0] mem_rdata_q;

  logic        if_elig, mem_elig, serving, in_range;

  // A request is ignored during its own ack cycle so a held level is not served twice.
  assign if_elig  = bus.if_req && !if_ack_q;
  assign mem_elig = bus.mem_req && !mem_ack_q;
  assign serving  = (state_q != IDLE);
  assign in_range = ((lat_addr_q >> ADDR_BITS) == 32'd0);

  ram_arb_prio #(.FIXED_PRIO(FIXED_PRIO)) u_prio (
    .if_req     (if_elig),
    .mem_req    (mem_elig),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant         = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 32'd0;
    bus.ram_sel   = 4'd0;
    bus.ram_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (if_elig || mem_elig) begin
          grant   = 1'b1;
          state_d = (winner == GRANT_MEM) ? SERVE_MEM : SERVE_IF;
        end
      end
      SERVE_IF, SERVE_MEM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (serving) begin
      // Reset in the access cycle must not let a partial write through.
      bus.ram_en    = !rst && in_range;
      bus.ram_we    = lat_we_q;
      bus.ram_addr  = lat_addr_q;
      bus.ram_sel   = lat_sel_q;
      bus.ram_wdata = lat_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_IF;
      lat_addr_q   <= 32'd0;
      lat_we_q     <= 1'b0;
      lat_sel_q    <= 4'd0;
      lat_wdata_q  <= 32'd0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= 32'd0;
      mem_ack_q    <= 1'b0;
      mem_err_q    <= 1'b0;
      mem_rdata_q  <= 32'd0;
    end else begin
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_ack_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= 32'd0;
      if (grant) begin
        last_grant_q <= winner;
        if (winner == GRANT_MEM) begin
          lat_addr_q  <= bus.mem_addr;
          lat_we_q    <= bus.mem_we;
          lat_sel_q   <= bus.mem_sel;
          lat_wdata_q <= bus.mem_wdata;
        end else begin
          lat_addr_q  <= bus.if_addr;
          lat_we_q    <= 1'b0;
          lat_sel_q   <= IF_SEL;
          lat_wdata_q <= 32'd0;
        end
      end
      if (state_q == SERVE_IF) begin
        if_ack_q   <= 1'b1;
        if_err_q   <= !in_range;
        if_rdata_q <= in_range ? bus.ram_rdata : 32'd0;
      end
      if (state_q == SERVE_MEM) begin
        mem_ack_q   <= 1'b1;
        mem_err_q   <= !in_range;
        mem_rdata_q <= (in_range && !lat_we_q) ? bus.ram_rdata : 32'd0;
      end
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.stall     = (bus.if_req && !if_ack_q) || (bus.mem_req && !mem_ack_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter, round-robin (dut 0) and fixed-priority (dut 1)
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req    [2] = '{1'b0, 1'b0};
  logic [31:0] if_addr   [2] = '{32'd0, 32'd0};
  logic        mem_req   [2] = '{1'b0, 1'b0};
  logic        mem_we    [2] = '{1'b0, 1'b0};
  logic [31:0] mem_addr  [2] = '{32'd0, 32'd0};
  logic [3:0]  mem_sel   [2] = '{4'd0, 4'd0};
  logic [31:0] mem_wdata [2] = '{32'd0, 32'd0};

  logic        d_if_ack  [2];
  logic [31:0] d_if_rdata[2];
  logic        d_if_err  [2];
  logic        d_mem_ack [2];
  logic [31:0] d_mem_rdata[2];
  logic        d_mem_err [2];
  logic        d_ram_en  [2];
  logic        d_ram_we  [2];
  logic [31:0] d_ram_addr[2];
  logic [3:0]  d_ram_sel [2];
  logic [31:0] d_ram_wdata[2];
  logic        d_stall   [2];
  logic [31:0] ram_word_300[2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] init_word(input int i);
    logic [15:0] v;
    v = i[15:0];
    case (i)
      32'h40:  return 32'hDEADBEEF;
      32'h80:  return 32'hAABBCCDD;
      32'hC0:  return 32'h0BADF00D;
      default: return {v, ~v};
    endcase
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return a[31:19] == 13'd0;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h", name, d, got, exp);
  endtask

  ram_arbiter_if arb_bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] ram_m [1024];

    ram_arbiter #(.FIXED_PRIO(g), .ADDR_BITS(19)) dut (
      .clk (clk),
      .rst (rst),
      .bus (arb_bus[g])
    );

    assign arb_bus[g].if_req    = if_req[g];
    assign arb_bus[g].if_addr   = if_addr[g];
    assign arb_bus[g].mem_req   = mem_req[g];
    assign arb_bus[g].mem_we    = mem_we[g];
    assign arb_bus[g].mem_addr  = mem_addr[g];
    assign arb_bus[g].mem_sel   = mem_sel[g];
    assign arb_bus[g].mem_wdata = mem_wdata[g];
    assign arb_bus[g].ram_rdata = ram_m[arb_bus[g].ram_addr[11:2]];

    assign d_if_ack[g]    = arb_bus[g].if_ack;
    assign d_if_rdata[g]  = arb_bus[g].if_rdata;
    assign d_if_err[g]    = arb_bus[g].if_err;
    assign d_mem_ack[g]   = arb_bus[g].mem_ack;
    assign d_mem_rdata[g] = arb_bus[g].mem_rdata;
    assign d_mem_err[g]   = arb_bus[g].mem_err;
    assign d_ram_en[g]    = arb_bus[g].ram_en;
    assign d_ram_we[g]    = arb_bus[g].ram_we;
    assign d_ram_addr[g]  = arb_bus[g].ram_addr;
    assign d_ram_sel[g]   = arb_bus[g].ram_sel;
    assign d_ram_wdata[g] = arb_bus[g].ram_wdata;
    assign d_stall[g]     = arb_bus[g].stall;
    assign ram_word_300[g] = ram_m[10'hC0];

    initial begin
      for (int i = 0; i < 1024; i++) ram_m[i] = init_word(i);
      forever begin
        @(posedge clk);
        if (arb_bus[g].ram_en && arb_bus[g].ram_we) begin
          for (int b = 0; b < 4; b++) begin
            if (arb_bus[g].ram_sel[b])
              ram_m[arb_bus[g].ram_addr[11:2]][8*b +: 8] <= arb_bus[g].ram_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Transaction-level reference: m_busy = port whose RAM access happens this cycle (-1 none),
  // m_ack = port acknowledged this cycle; a fresh grant is only possible in a non-access cycle.
  int          m_busy [2] = '{-1, -1};
  int          m_ack  [2] = '{-1, -1};
  int          m_last [2] = '{0, 0};
  logic [31:0] m_data [2] = '{32'd0, 32'd0};
  logic        m_err  [2] = '{1'b0, 1'b0};
  logic [31:0] m_addr [2] = '{32'd0, 32'd0};
  logic        m_we   [2] = '{1'b0, 1'b0};
  logic [3:0]  m_sel  [2] = '{4'd0, 4'd0};
  logic [31:0] m_wd   [2] = '{32'd0, 32'd0};
  logic [31:0] ref_m  [2][1024];

  initial begin
    int nb, na, idx;
    logic [31:0] nd;
    logic ne, ie, me;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 1024; i++) ref_m[d][i] = init_word(i);
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_busy[d] = -1; m_ack[d] = -1; m_last[d] = 0; m_data[d] = 0; m_err[d] = 0;
        end else begin
          na = -1; nd = 0; ne = 0; nb = -1;
          if (m_busy[d] >= 0) begin
            na  = m_busy[d];
            idx = int'(m_addr[d][11:2]);
            if (!in_rng(m_addr[d])) ne = 1;
            else if (m_we[d]) begin
              for (int b = 0; b < 4; b++)
                if (m_sel[d][b]) ref_m[d][idx][8*b +: 8] = m_wd[d][8*b +: 8];
            end else nd = ref_m[d][idx];
          end else begin
            ie = if_req[d] && (m_ack[d] != 0);
            me = mem_req[d] && (m_ack[d] != 1);
            if (ie && me) nb = (d == 1) ? 1 : 1 - m_last[d];
            else if (me) nb = 1;
            else if (ie) nb = 0;
            if (nb == 1) begin
              m_addr[d] = mem_addr[d]; m_we[d] = mem_we[d]; m_sel[d] = mem_sel[d]; m_wd[d] = mem_wdata[d];
            end else if (nb == 0) begin
              m_addr[d] = if_addr[d]; m_we[d] = 1'b0; m_sel[d] = 4'hF; m_wd[d] = 32'd0;
            end
            if (nb >= 0) m_last[d] = nb;
          end
          m_busy[d] = nb; m_ack[d] = na; m_data[d] = nd; m_err[d] = ne;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic busy;
      busy = (m_busy[d] >= 0);
      chk("if_ack", d, 32'(d_if_ack[d]), 32'(m_ack[d] == 0));
      chk("mem_ack", d, 32'(d_mem_ack[d]), 32'(m_ack[d] == 1));
      if (m_ack[d] == 0) begin
        chk("if_rdata", d, d_if_rdata[d], m_data[d]);
        chk("if_err", d, 32'(d_if_err[d]), 32'(m_err[d]));
      end
      if (m_ack[d] == 1) begin
        chk("mem_rdata", d, d_mem_rdata[d], m_data[d]);
        chk("mem_err", d, 32'(d_mem_err[d]), 32'(m_err[d]));
      end
      chk("ram_en", d, 32'(d_ram_en[d]), 32'(busy && in_rng(m_addr[d]) && !rst));
      chk("ram_we", d, 32'(d_ram_we[d]), busy ? 32'(m_we[d]) : 32'd0);
      chk("ram_addr", d, d_ram_addr[d], busy ? m_addr[d] : 32'd0);
      chk("ram_sel", d, 32'(d_ram_sel[d]), busy ? 32'(m_sel[d]) : 32'd0);
      chk("ram_wdata", d, d_ram_wdata[d], busy ? m_wd[d] : 32'd0);
      chk("stall", d, 32'(d_stall[d]),
          32'((if_req[d] && m_ack[d] != 0) || (mem_req[d] && m_ack[d] != 1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int d, input int p, input logic we, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int ack_cyc, output int en_cyc);
    tick();
    if (p == 0) begin
      if_req[d] = 1'b1; if_addr[d] = a;
    end else begin
      mem_req[d] = 1'b1; mem_we[d] = we; mem_addr[d] = a; mem_sel[d] = s; mem_wdata[d] = wd;
    end
    ack_cyc = -1; en_cyc = -1; rd = 32'd0; er = 1'b0;
    for (int c = 0; c < 10 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (d_ram_en[d] && en_cyc < 0) en_cyc = c;
      if (p == 0 && d_if_ack[d]) begin ack_cyc = c; rd = d_if_rdata[d]; er = d_if_err[d]; end
      if (p == 1 && d_mem_ack[d]) begin ack_cyc = c; rd = d_mem_rdata[d]; er = d_mem_err[d]; end
      tick();
    end
    if (p == 0) if_req[d] = 1'b0;
    else mem_req[d] = 1'b0;
  endtask

  task automatic tie(input int d, output int order, output int nacks);
    int got_if, got_mem;
    tick();
    if_req[d] = 1'b1; if_addr[d] = 32'h104;
    mem_req[d] = 1'b1; mem_we[d] = 1'b0; mem_addr[d] = 32'h204; mem_sel[d] = 4'hF;
    order = 0; nacks = 0; got_if = 0; got_mem = 0;
    for (int c = 0; c < 30 && (if_req[d] || mem_req[d]); c++) begin
      @(negedge clk);
      if (d_if_ack[d])  begin order = order * 2;     nacks++; got_if++;  end
      if (d_mem_ack[d]) begin order = order * 2 + 1; nacks++; got_mem++; end
      tick();
      if (got_if >= 2)  if_req[d] = 1'b0;
      if (got_mem >= 2) mem_req[d] = 1'b0;
    end
    if_req[d] = 1'b0; mem_req[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int ac, ec, order, nacks;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_if_ack", d, 32'(d_if_ack[d]), 32'd0);
      chk("rst_mem_ack", d, 32'(d_mem_ack[d]), 32'd0);
      chk("rst_ram_en", d, 32'(d_ram_en[d]), 32'd0);
      chk("rst_stall", d, 32'(d_stall[d]), 32'd0);
    end

    for (int d = 0; d < 2; d++) begin
      access(d, 0, 1'b0, 32'h100, 4'hF, 32'd0, rd, er, ac, ec);
      chk("fetch_rdata", d, rd, 32'hDEADBEEF);
      chk("fetch_err", d, 32'(er), 32'd0);
      chk("fetch_ack_cycle", d, ac, 32'd2);
      chk("fetch_en_cycle", d, ec, 32'd1);

      access(d, 1, 1'b1, 32'h200, 4'b0011, 32'h11223344, rd, er, ac, ec);
      chk("store_rdata", d, rd, 32'd0);
      chk("store_err", d, 32'(er), 32'd0);
      access(d, 1, 1'b0, 32'h200, 4'hF, 32'd0, rd, er, ac, ec);
      chk("load_merged", d, rd, 32'hAABB3344);

      access(d, 1, 1'b0, 32'h0008_0000, 4'hF, 32'd0, rd, er, ac, ec);
      chk("oor_err", d, 32'(er), 32'd1);
      chk("oor_rdata", d, rd, 32'd0);
      chk("oor_en_never", d, ec, 32'hFFFF_FFFF);
      chk("oor_ack_cycle", d, ac, 32'd2);
    end

    // Last grant was MEM: round-robin hands the tie to IF, fixed priority to MEM.
    for (int d = 0; d < 2; d++) begin
      tie(d, order, nacks);
      chk("tie_after_mem_acks", d, nacks, 32'd4);
      chk("tie_after_mem_order", d, order, (d == 0) ? 32'd5 : 32'd10);
    end

    for (int d = 0; d < 2; d++) begin
      tick();
      mem_req[d] = 1'b1; mem_we[d] = 1'b1; mem_addr[d] = 32'h300;
      mem_sel[d] = 4'hF; mem_wdata[d] = 32'h55555555;
      tick();
      rst = 1'b1; mem_req[d] = 1'b0;
      @(negedge clk);
      chk("rst_serve_en", d, 32'(d_ram_en[d]), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_serve_no_ack", d, 32'(d_mem_ack[d]), 32'd0);
      chk("rst_serve_rdata", d, d_mem_rdata[d], 32'd0);
      chk("rst_serve_addr", d, d_ram_addr[d], 32'd0);
      chk("rst_serve_stall", d, 32'(d_stall[d]), 32'd0);
      chk("rst_serve_word", d, ram_word_300[d], 32'h0BADF00D);
    end

    // After reset last_grant is IF, so both variants start the tie with MEM.
    for (int d = 0; d < 2; d++) begin
      tie(d, order, nacks);
      chk("tie_after_rst_acks", d, nacks, 32'd4);
      chk("tie_after_rst_order", d, order, 32'd10);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
